trivium_stream_xor: RTL and testbench
=====================================

// Module: trivium_stream_xor
// PURPOSE
//  Consumer side of the Trivium keystream generator. Drives the generator's enable and
//  active-low reset, and discards the warm-up bits. Packs the remaining keystream bits
//  LSB-first into bytes and XORs each byte with a byte-wide data stream.
//  Encryption and decryption are the same operation.
//  Sits between the generator and the byte-stream datapath.
// PARAMETERS
//  DISCARD_BITS  1153  keystream bits captured and thrown away after each start
// PORTS
//  clk          in   1  clock
//  rst          in   1  synchronous, active-high reset
//  start        in   1  pulse: re-key generator, flush buffers, begin warm-up
//  gen_rst_n    out  1  to generator reset; low for exactly the cycle after start/rst
//  ks_en        out  1  to generator enable
//  ks_bit       in   1  generator keystream_bit; valid the cycle after ks_en was high
//  in_valid     in   1  input byte valid
//  in_ready     out  1  input byte accepted when in_valid&in_ready
//  in_data      in   8  plaintext/ciphertext byte
//  out_valid    out  1  output byte valid
//  out_ready    in   1  downstream accepts when out_valid&out_ready
//  out_data     out  8  in_data ^ keystream byte
//  busy         out  1  high while in WARMUP
// BEHAVIOUR
//  Reset: state=IDLE; ks_en=0; in_ready=0; out_valid=0; out_data=0; busy=0.
//   gen_rst_n=0 in the cycle after rst, else 1. Clear bit count, pend, kb_valid, discard count.
//  pend = ks_en registered. ks_bit is captured only in cycles where pend=1.
//  Shift reg sr[7:0]: on capture, sr<={ks_bit,sr[7:1]}. The first keystream bit lands in bit0.
//  States:
//   IDLE: ks_en=0. start -> WARMUP.
//   WARMUP: ks_en=1 every cycle; captured bits discarded and counted.
//    On the DISCARD_BITS-th capture -> RUN. The next captured bit is keystream bit 0.
//   RUN: fill and XOR.
//  start in any state, including RUN: next state WARMUP.
//   Flushes sr, count, kb_valid, out_valid. gen_rst_n=0 for 1 cycle. ks_en=0 that cycle.
//   Discard counter restarts at 0.
//  Fill (RUN):
//   On the 8th capture, sr moves to byte buffer kb (kb_valid=1) if kb is empty or consumed
//    this cycle, and count=0. Otherwise count holds at 8 until kb frees.
//   ks_en = !(kb_valid && count+pend >= 8). No bit is dropped or duplicated.
//  XOR:
//   in_ready = RUN && kb_valid && (!out_valid || out_ready).
//   On accept: out_data <= in_data ^ kb; out_valid <= 1; kb consumed.
//   Latency: 1 cycle.
//   out_valid/out_data hold stable until out_ready. out_valid falls after accept with no new input.
//  Simultaneous:
//   Accept and kb refill in the same cycle are legal; kb is reloaded, not cleared.
//   start overrides accept; a byte offered in that cycle is not taken.
// CONFIGURATION
//  TRIVIUM_XOR_STATS_EN defined:
//   Adds output byte_cnt[31:0]: bytes accepted since last start/rst. Cleared by both.
//   Wraps 0xFFFFFFFF->0.
//  Undefined: no byte_cnt port, no counter logic; all else identical.
// TESTING
//  Reset -> ks_en=0, in_ready=0, out_valid=0, busy=0, gen_rst_n=0 for 1 cycle then 1.
//  start with stub gen (bit=1,0,1,0..)
//   -> busy high for 1153 captures, then RUN.
//   First kb=0x55; in_data 0x00 -> out_data 0x55 one cycle later.
//  Stream 0x00,0xFF,0x3C back-to-back, out_ready=1
//   -> 0x55,0xAA,0x69 on consecutive cycles. in_ready stalls only while kb refills.
//  out_ready low 5 cycles mid-stream
//   -> out_data held, in_ready=0, ks_en falls once count+pend>=8 with kb full.
//   No bit lost after release.
//  start in RUN with out_valid=1
//   -> out_valid=0 next cycle, busy=1, gen_rst_n low 1 cycle, full 1153-bit discard again.
//  Two instances on identical stub gens (encrypt then decrypt) -> recovered bytes == sent bytes.
//   With STATS_EN: byte_cnt=3 after 3 accepts, 0 after start.

Source files
------------

// File: rtl/trivium_stream_xor.sv
// Trivium keystream consumer: sequences the generator, discards warm-up bits, packs
// keystream LSB-first into bytes and XORs them onto a byte stream. Optional macro
// TRIVIUM_XOR_STATS_EN adds a byte_cnt output counting accepted bytes.
module trivium_stream_xor #(
  parameter int DISCARD_BITS = 1153
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gen_rst_n,
  output logic       ks_en,
  input  logic       ks_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
`ifdef TRIVIUM_XOR_STATS_EN
  ,
  output logic [31:0] byte_cnt
`endif
);

  localparam int DW = $clog2(DISCARD_BITS + 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t          state, state_nxt;
  logic            pend;
  logic [7:0]      sr, kb;
  logic [3:0]      cnt, cnt_inc;
  logic            kb_valid;
  logic [DW-1:0]   disc_cnt;
  logic            cap, run_cap, accept, kb_load, disc_last;
  logic [7:0]      sr_shift;

  assign cap       = pend && (state != IDLE);
  assign run_cap   = pend && (state == RUN);
  assign disc_last = (disc_cnt == DW'(DISCARD_BITS - 1));
  assign sr_shift  = {ks_bit, sr[7:1]};
  assign cnt_inc   = cnt + {3'b000, run_cap};
  assign accept    = in_valid && in_ready;
  // cnt tops out at 8: the enable throttle below stops requests before a 9th bit can land
  assign kb_load   = (state == RUN) && (cnt_inc == 4'd8) && (!kb_valid || accept);
  assign busy      = (state == WARMUP);

  always_comb begin
    state_nxt = state;
    ks_en     = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: ;
      WARMUP: begin
        ks_en = gen_rst_n;
        if (cap && disc_last) state_nxt = RUN;
      end
      RUN: begin
        ks_en    = !(kb_valid && ((cnt + {3'b000, pend}) >= 4'd8));
        in_ready = kb_valid && (!out_valid || out_ready);
      end
      default: state_nxt = IDLE;
    endcase
    // start wins over everything: no request, no accept, re-key next cycle
    if (start) begin
      state_nxt = WARMUP;
      ks_en     = 1'b0;
      in_ready  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gen_rst_n <= 1'b0;
      pend      <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
      kb        <= '0;
      kb_valid  <= 1'b0;
      disc_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      gen_rst_n <= !start;
      pend      <= ks_en;
      if (start) begin
        sr        <= '0;
        cnt       <= '0;
        kb_valid  <= 1'b0;
        disc_cnt  <= '0;
        out_valid <= 1'b0;
      end else begin
        if ((state == WARMUP) && cap) disc_cnt <= disc_cnt + DW'(1);
        if (run_cap) sr <= sr_shift;
        if (kb_load) begin
          kb       <= run_cap ? sr_shift : sr;
          kb_valid <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt_inc;
          if (accept) kb_valid <= 1'b0;
        end
        if (accept) begin
          out_data  <= in_data ^ kb;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef TRIVIUM_XOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start) byte_cnt <= '0;
    else if (accept)  byte_cnt <= byte_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Directed bench: encrypt instance plus decrypt instance, each fed by an alternating-bit
// generator stub; checks warm-up length, byte packing, backpressure and restart.
module tb_trivium_stream_xor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       e_start, e_grn, e_ks_en, e_ks_bit, e_iv, e_ir, e_ov, e_or, e_busy;
  logic [7:0] e_id, e_od;
  logic       d_start, d_grn, d_ks_en, d_ks_bit, d_iv, d_ir, d_ov, d_or, d_busy;
  logic [7:0] d_id, d_od;
`ifdef TRIVIUM_XOR_STATS_EN
  logic [31:0] e_bc, d_bc;
`endif

  trivium_stream_xor u_enc (
    .clk(clk), .rst(rst), .start(e_start), .gen_rst_n(e_grn), .ks_en(e_ks_en),
    .ks_bit(e_ks_bit), .in_valid(e_iv), .in_ready(e_ir), .in_data(e_id),
    .out_valid(e_ov), .out_ready(e_or), .out_data(e_od), .busy(e_busy)
`ifdef TRIVIUM_XOR_STATS_EN
    , .byte_cnt(e_bc)
`endif
  );

  trivium_stream_xor u_dec (
    .clk(clk), .rst(rst), .start(d_start), .gen_rst_n(d_grn), .ks_en(d_ks_en),
    .ks_bit(d_ks_bit), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
    .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .busy(d_busy)
`ifdef TRIVIUM_XOR_STATS_EN
    , .byte_cnt(d_bc)
`endif
  );

  // Stub generator: bit k = k&1, so after 1153 discards keystream bit 0 is 1 -> bytes 0x55
  logic e_ph = 1'b0, d_ph = 1'b0;
  initial begin e_ks_bit = 1'b0; d_ks_bit = 1'b0; end
  always @(posedge clk) begin
    if (!e_grn) begin e_ph <= 1'b0; e_ks_bit <= 1'b0; end
    else if (e_ks_en) begin e_ks_bit <= e_ph; e_ph <= ~e_ph; end
    if (!d_grn) begin d_ph <= 1'b0; d_ks_bit <= 1'b0; end
    else if (d_ks_en) begin d_ks_bit <= d_ph; d_ph <= ~d_ph; end
  end

  logic [7:0] eq[$];
  logic [7:0] dq[$];
  always @(negedge clk) begin
    if (e_ov && e_or) eq.push_back(e_od);
    if (d_ov && d_or) dq.push_back(d_od);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input bit d);
    @(posedge clk); #1;
    if (d) d_start = 1'b1; else e_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0; e_start = 1'b0;
  endtask

  task automatic warm(input bit d, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    chk({tag, "_grn_lo"}, d ? d_grn : e_grn, 0);
    chk({tag, "_ks_en_lo"}, d ? d_ks_en : e_ks_en, 0);
    chk({tag, "_busy"}, d ? d_busy : e_busy, 1);
    chk({tag, "_ov_flush"}, d ? d_ov : e_ov, 0);
    n = 1;
    @(negedge clk);
    chk({tag, "_grn_hi"}, d ? d_grn : e_grn, 1);
    while ((d ? d_busy : e_busy) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 1155);
  endtask

  task automatic send(input bit d, input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    if (d) begin d_iv = 1'b1; d_id = b; end
    else   begin e_iv = 1'b1; e_id = b; end
    @(negedge clk);
    while (!(d ? d_ir : e_ir) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    d_iv = 1'b0; e_iv = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e_exp[7];
    logic [7:0] d_exp[3];
    e_exp = '{8'h55, 8'hAA, 8'h69, 8'h47, 8'hA5, 8'h5A, 8'h55};
    d_exp = '{8'h00, 8'hFF, 8'h3C};
    rst = 1'b1;
    e_start = 0; e_iv = 0; e_id = 0; e_or = 1;
    d_start = 0; d_iv = 0; d_id = 0; d_or = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grn_lo", e_grn, 0);
    chk("rst_ks_en", e_ks_en, 0);
    chk("rst_in_ready", e_ir, 0);
    chk("rst_out_valid", e_ov, 0);
    chk("rst_out_data", e_od, 0);
    chk("rst_busy", e_busy, 0);
    @(negedge clk);
    chk("rst_grn_hi", e_grn, 1);
    chk("idle_ks_en", e_ks_en, 0);

    pulse(0);
    warm(0, "w1");

    send(0, 8'h00);
    @(negedge clk);
    chk("first_ov", e_ov, 1);
    chk("first_od", e_od, 8'h55);
    send(0, 8'hFF);
    send(0, 8'h3C);
`ifdef TRIVIUM_XOR_STATS_EN
    @(negedge clk);
    chk("byte_cnt3", e_bc, 3);
`endif

    // backpressure: hold output, let the refill saturate
    @(posedge clk); #1;
    e_or = 1'b0;
    send(0, 8'h12);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i < 5) begin
        chk("hold_ov", e_ov, 1);
        chk("hold_od", e_od, 8'h47);
        chk("hold_ir", e_ir, 0);
      end
    end
    chk("stall_ks_en", e_ks_en, 0);
    @(posedge clk); #1;
    e_or = 1'b1;
    send(0, 8'hF0);
    send(0, 8'h0F);

    // restart while a result is pending, with a byte offered in the start cycle
    @(posedge clk); #1;
    e_or = 1'b0;
    send(0, 8'h00);
    @(negedge clk);
    chk("pre_start_ov", e_ov, 1);
    @(posedge clk); #1;
    e_start = 1'b1; e_iv = 1'b1; e_id = 8'h77;
    @(negedge clk);
    chk("start_ir", e_ir, 0);
    chk("start_ks_en", e_ks_en, 0);
    @(posedge clk); #1;
    e_start = 1'b0; e_iv = 1'b0;
    warm(0, "w2");
`ifdef TRIVIUM_XOR_STATS_EN
    chk("byte_cnt0", e_bc, 0);
`endif
    e_or = 1'b1;
    send(0, 8'h00);
    @(negedge clk);
    chk("restart_od", e_od, 8'h55);
    @(posedge clk); #1;

    chk("enc_count", eq.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < eq.size()) chk($sformatf("enc[%0d]", i), eq[i], e_exp[i]);

    // decrypt the first three ciphertext bytes on the second instance
    pulse(1);
    warm(1, "w3");
    send(1, 8'h55);
    send(1, 8'hAA);
    send(1, 8'h69);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("dec_count", dq.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < dq.size()) chk($sformatf("dec[%0d]", i), dq[i], d_exp[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
